if_pc_btb: RTL and testbench

Fetch-stage PC generator with a direct-mapped branch target buffer (BTB), sitting directly upstream of the IF-ID segment register. Each cycle it drives `PCF` to the instruction RAM address and the IF-ID register, and predicts the next PC (`NPCPredF`) from BTB contents. Branch/jump outcomes resolved in EX train the BTB. On a misprediction the block raises `RedirectE` and loads the correct PC.

---
 rtl/if_pc_btb.sv | 136 +++++++++++++
 tb/tb_if_pc_btb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_pc_btb.sv
// if_pc_btb: fetch-stage PC generator with a direct-mapped branch target buffer.
//
// The block drives the current fetch PC and predicts the next one from the
// BTB. Branch and jump outcomes resolved in EX train the BTB. A mispredicted
// EX instruction raises RedirectE and reloads the PC.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   en          fetch enable (~StallF); 0 holds PCF unless a redirect occurs
//   PCF         current fetch PC (registered)
//   NPCPredF    predicted next PC for PCF (combinational)
//   PredTakenF  BTB hit at PCF with a taken-leaning counter
//   CtrlE       one-cycle pulse: EX holds a resolved branch/JAL/JALR
//   PCE         PC of the EX instruction
//   TakenE      actual direction of the EX instruction
//   TargetE     actual taken target (low two bits ignored)
//   NPCPredE    prediction that travelled with the EX instruction
//   RedirectE   misprediction flag (combinational)
//   RedirectPC  correct next PC for the EX instruction
module if_pc_btb #(
    parameter int          BTB_ENTRIES = 8,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] PCF,
    output logic [31:0] NPCPredF,
    output logic        PredTakenF,
    input  logic        CtrlE,
    input  logic [31:0] PCE,
    input  logic        TakenE,
    input  logic [31:0] TargetE,
    input  logic [31:0] NPCPredE,
    output logic        RedirectE,
    output logic [31:0] RedirectPC
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX;

    // Saturating 2-bit counter step toward "taken".
    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'b01;
    endfunction

    // Saturating 2-bit counter step toward "not taken".
    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'b01;
    endfunction

    logic             valid_r [BTB_ENTRIES];
    logic [TAG_W-1:0] tag_r   [BTB_ENTRIES];
    logic [29:0]      tgt_r   [BTB_ENTRIES];
    logic [1:0]       cnt_r   [BTB_ENTRIES];
    logic [31:0]      pcf_r;

    logic [IDX-1:0]   f_idx_s;
    logic [TAG_W-1:0] f_tag_s;
    logic             f_hit_s;
    logic             pred_taken_s;
    logic [31:0]      npc_pred_s;
    logic [IDX-1:0]   e_idx_s;
    logic [TAG_W-1:0] e_tag_s;
    logic             e_hit_s;
    logic [31:0]      redirect_pc_s;
    logic             redirect_s;

    // Only the word-aligned part of TargetE is meaningful.
    logic             unused_target_lsb_s;
    assign unused_target_lsb_s = &{1'b0, TargetE[1:0]};

    // Fetch-side lookup: prediction is built from the pre-write BTB contents.
    always_comb begin
        f_idx_s      = pcf_r[IDX+1:2];
        f_tag_s      = pcf_r[31:IDX+2];
        f_hit_s      = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
        pred_taken_s = f_hit_s && cnt_r[f_idx_s][1];
        npc_pred_s   = pred_taken_s ? {tgt_r[f_idx_s], 2'b00} : (pcf_r + 32'd4);
    end

    // EX-side lookup and misprediction detection; redirect is masked in reset.
    always_comb begin
        e_idx_s       = PCE[IDX+1:2];
        e_tag_s       = PCE[31:IDX+2];
        e_hit_s       = valid_r[e_idx_s] && (tag_r[e_idx_s] == e_tag_s);
        redirect_pc_s = TakenE ? {TargetE[31:2], 2'b00} : (PCE + 32'd4);
        redirect_s    = rst && CtrlE && (redirect_pc_s != NPCPredE);
    end

    // BTB training from resolved EX control-flow instructions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
                tag_r[i]   <= {TAG_W{1'b0}};
                tgt_r[i]   <= 30'd0;
                cnt_r[i]   <= 2'b01;
            end
        end else if (CtrlE) begin
            if (e_hit_s) begin
                if (TakenE) begin
                    cnt_r[e_idx_s] <= sat_inc(cnt_r[e_idx_s]);
                    tgt_r[e_idx_s] <= TargetE[31:2];
                end else begin
                    cnt_r[e_idx_s] <= sat_dec(cnt_r[e_idx_s]);
                end
            end else if (TakenE) begin
                // Direct-mapped: a taken miss evicts whatever lives at this index.
                valid_r[e_idx_s] <= 1'b1;
                tag_r[e_idx_s]   <= e_tag_s;
                tgt_r[e_idx_s]   <= TargetE[31:2];
                cnt_r[e_idx_s]   <= 2'b10;
            end
        end
    end

    // Fetch PC register: a redirect overrides a stall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pcf_r <= RESET_PC;
        end else if (redirect_s) begin
            pcf_r <= redirect_pc_s;
        end else if (en) begin
            pcf_r <= npc_pred_s;
        end
    end

    assign PCF        = pcf_r;
    assign NPCPredF   = npc_pred_s;
    assign PredTakenF = pred_taken_s;
    assign RedirectE  = redirect_s;
    assign RedirectPC = redirect_pc_s;

endmodule

// File: tb/tb_if_pc_btb.sv
module tb_if_pc_btb;

    localparam int          NE   = 8;
    localparam logic [31:0] RPC  = 32'h0000_0100;

    logic        clk;
    logic        rst;
    logic        en;
    logic [31:0] PCF;
    logic [31:0] NPCPredF;
    logic        PredTakenF;
    logic        CtrlE;
    logic [31:0] PCE;
    logic        TakenE;
    logic [31:0] TargetE;
    logic [31:0] NPCPredE;
    logic        RedirectE;
    logic [31:0] RedirectPC;

    int n_chk  = 0;
    int n_fail = 0;

    if_pc_btb #(.BTB_ENTRIES(NE), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .en(en),
        .PCF(PCF), .NPCPredF(NPCPredF), .PredTakenF(PredTakenF),
        .CtrlE(CtrlE), .PCE(PCE), .TakenE(TakenE), .TargetE(TargetE),
        .NPCPredE(NPCPredE), .RedirectE(RedirectE), .RedirectPC(RedirectPC)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ctrl;
        logic [31:0] pce;
        logic        taken;
        logic [31:0] tgt;
        logic [31:0] npce;
        logic [31:0] pcf;
        logic        ptf;
        logic [31:0] npf;
        logic        rd;
        logic [31:0] rpc;
        logic [31:0] nxt;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic e, input logic c, input logic [31:0] pce, input logic t,
                       input logic [31:0] tgt, input logic [31:0] npce, input logic [31:0] pcf,
                       input logic ptf, input logic [31:0] npf, input logic rd,
                       input logic [31:0] rpc, input logic [31:0] nxt);
        vec_t v;
        v.en = e; v.ctrl = c; v.pce = pce; v.taken = t; v.tgt = tgt; v.npce = npce;
        v.pcf = pcf; v.ptf = ptf; v.npf = npf; v.rd = rd; v.rpc = rpc; v.nxt = nxt;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic e, input logic c, input logic [31:0] pce, input logic t,
                         input logic [31:0] tgt, input logic [31:0] npce);
        en = e; CtrlE = c; PCE = pce; TakenE = t; TargetE = tgt; NPCPredE = npce;
    endtask

    // Behavioural reference model: BTB as plain arrays, full-address targets.
    bit          m_valid [NE];
    logic [31:0] m_tag   [NE];
    logic [31:0] m_tgt   [NE];
    int          m_cnt   [NE];
    logic [31:0] m_pc;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 32'd4) % NE);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == pc / (32'd4 * NE));
    endfunction

    function automatic bit m_ptaken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_npred(input logic [31:0] pc);
        return m_ptaken(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NE; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 32'd0; m_tgt[i] = 32'd0; m_cnt[i] = 1;
        end
        m_pc = RPC;
    endtask

    initial begin
        logic [31:0] exp_rpc;
        logic        exp_rd;
        logic [31:0] exp_nxt;
        int          k;

        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        #1 rst = 1'b0;

        // Reset state, with a would-be misprediction on the EX inputs.
        repeat (2) @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 32'h0000_0100, 1'b1, 32'h0000_0200, 32'h0000_0000);
        #1;
        chk("reset_pcf", PCF, RPC);
        chk("reset_ptf", {31'd0, PredTakenF}, 32'd0);
        chk("reset_npf", NPCPredF, RPC + 32'd4);
        chk("reset_rd", {31'd0, RedirectE}, 32'd0);
        @(posedge clk);
        #1;
        chk("reset_hold_pcf", PCF, RPC);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;

        // Directed table: sequential fetch, training, saturation, stall, alias, wrap, JALR.
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h100, 0, 32'h104, 0, 32'h0, 32'h104);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h104, 0, 32'h108, 0, 32'h0, 32'h108);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h108, 0, 32'h10C, 0, 32'h0, 32'h10C);
        add(1, 1, 32'h108, 1, 32'h200, 32'h10C, 32'h10C, 0, 32'h110, 1, 32'h200, 32'h200);
        add(1, 1, 32'h100, 0, 32'h0, 32'h200, 32'h200, 0, 32'h204, 1, 32'h104, 32'h104);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h104, 0, 32'h108, 0, 32'h0, 32'h108);
        add(1, 1, 32'h108, 0, 32'h0, 32'h200, 32'h108, 1, 32'h200, 1, 32'h10C, 32'h10C);
        add(0, 1, 32'h108, 0, 32'h0, 32'h10C, 32'h10C, 0, 32'h110, 0, 32'h10C, 32'h10C);
        add(0, 1, 32'h108, 0, 32'h0, 32'h10C, 32'h10C, 0, 32'h110, 0, 32'h10C, 32'h10C);
        add(0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h10C, 0, 32'h110, 0, 32'h0, 32'h10C);
        add(0, 1, 32'h104, 0, 32'h0, 32'h300, 32'h10C, 0, 32'h110, 1, 32'h108, 32'h108);
        add(0, 0, 32'h0, 0, 32'h0, 32'h0, 32'h108, 0, 32'h10C, 0, 32'h0, 32'h108);
        add(0, 1, 32'h128, 1, 32'h400, 32'h12C, 32'h108, 0, 32'h10C, 1, 32'h400, 32'h400);
        add(0, 1, 32'h104, 0, 32'h0, 32'h0, 32'h400, 0, 32'h404, 1, 32'h108, 32'h108);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h108, 0, 32'h10C, 0, 32'h0, 32'h10C);
        add(1, 1, 32'h124, 0, 32'h0, 32'h0, 32'h10C, 0, 32'h110, 1, 32'h128, 32'h128);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h128, 1, 32'h400, 0, 32'h0, 32'h400);
        add(1, 1, 32'hFFFF_FFF8, 0, 32'h0, 32'h0, 32'h400, 0, 32'h404, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 0, 32'h0, 0, 32'h0, 32'h0);
        add(1, 1, 32'h0, 1, 32'h203, 32'h4, 32'h0, 0, 32'h4, 1, 32'h200, 32'h200);
        add(1, 0, 32'h0, 0, 32'h0, 32'h0, 32'h200, 0, 32'h204, 0, 32'h0, 32'h204);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].ctrl, vecs[i].pce, vecs[i].taken, vecs[i].tgt, vecs[i].npce);
            #1;
            chk($sformatf("v%0d_pcf", i), PCF, vecs[i].pcf);
            chk($sformatf("v%0d_ptf", i), {31'd0, PredTakenF}, {31'd0, vecs[i].ptf});
            chk($sformatf("v%0d_npf", i), NPCPredF, vecs[i].npf);
            chk($sformatf("v%0d_rd", i), {31'd0, RedirectE}, {31'd0, vecs[i].rd});
            if (vecs[i].ctrl) chk($sformatf("v%0d_rpc", i), RedirectPC, vecs[i].rpc);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_next", i), PCF, vecs[i].nxt);
        end

        // Async reset mid-cycle during a mispredicted CtrlE pulse.
        drive(1'b1, 1'b1, 32'h128, 1'b1, 32'h500, 32'h0);
        #2 rst = 1'b0;
        #1;
        chk("midrst_pcf", PCF, RPC);
        chk("midrst_rd", {31'd0, RedirectE}, 32'd0);
        chk("midrst_npf", NPCPredF, RPC + 32'd4);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        rst = 1'b1;
        #1;
        chk("postrst_pcf", PCF, RPC);
        drive(1'b1, 1'b1, 32'h124, 1'b0, 32'h0, 32'h0);
        #1;
        chk("postrst_rd", {31'd0, RedirectE}, 32'd1);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 32'd0);
        #1;
        chk("postrst_alias_pcf", PCF, 32'h128);
        chk("postrst_alias_ptf", {31'd0, PredTakenF}, 32'd0);
        chk("postrst_alias_npf", NPCPredF, 32'h12C);

        // Randomized phase against the reference model from a fresh reset.
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        m_reset();
        for (int c = 0; c < 600; c++) begin
            logic [31:0] pce;
            logic [31:0] tgt;
            logic [31:0] npce;
            logic        tk;
            logic        ctl;
            logic        e;
            int          ci;
            e   = ($urandom_range(0, 3) != 0);
            ctl = ($urandom_range(0, 2) == 0);
            tk  = $urandom_range(0, 1);
            pce = 32'h100 + 32'd4 * 32'($urandom_range(0, 23));
            tgt = 32'h100 + 32'd4 * 32'($urandom_range(0, 23)) + 32'($urandom_range(0, 3));
            k   = $urandom_range(0, 2);
            if (k == 0)      npce = m_npred(pce);
            else if (k == 1) npce = pce + 32'd4;
            else             npce = {tgt[31:2], 2'b00};
            drive(e, ctl, pce, tk, tgt, npce);
            #1;
            exp_rpc = tk ? {tgt[31:2], 2'b00} : pce + 32'd4;
            exp_rd  = ctl && (exp_rpc != npce);
            chk("rnd_ptf", {31'd0, PredTakenF}, {31'd0, m_ptaken(m_pc)});
            chk("rnd_npf", NPCPredF, m_npred(m_pc));
            chk("rnd_rd", {31'd0, RedirectE}, {31'd0, exp_rd});
            chk("rnd_rpc", RedirectPC, exp_rpc);
            // Model: next PC from pre-update state, then train.
            exp_nxt = exp_rd ? exp_rpc : (e ? m_npred(m_pc) : m_pc);
            if (ctl) begin
                ci = m_idx(pce);
                if (m_hit(pce)) begin
                    if (tk) begin
                        m_cnt[ci] = (m_cnt[ci] < 3) ? m_cnt[ci] + 1 : 3;
                        m_tgt[ci] = {tgt[31:2], 2'b00};
                    end else begin
                        m_cnt[ci] = (m_cnt[ci] > 0) ? m_cnt[ci] - 1 : 0;
                    end
                end else if (tk) begin
                    m_valid[ci] = 1'b1;
                    m_tag[ci]   = pce / (32'd4 * NE);
                    m_tgt[ci]   = {tgt[31:2], 2'b00};
                    m_cnt[ci]   = 2;
                end
            end
            m_pc = exp_nxt;
            @(posedge clk);
            #1;
            chk("rnd_pcf", PCF, m_pc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
